e_m_pipe_reg: RTL and testbench

- E-to-M pipeline register of the 5-stage MIPS pipeline.
- Sits directly downstream of the E-stage Tnew generator and ALU. Latches the E-stage instruction, PC, ALU result, store data, destination register and E_Tnew.
- Ages Tnew by one stage and produces the M-stage forwarding source (valid/address/data) consumed by the hazard/forward unit.
- Supports stall (hold), flush (bubble insertion) and a saturating bubble counter for debug.

---
 rtl/mips_pipe_pkg.sv | 17 +
 rtl/tnew_age.sv | 9 +
 rtl/e_m_pipe_reg.sv | 61 ++++++
 tb/tb_e_m_pipe_reg.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: constants and stage-register field layout shared by the MIPS pipeline registers
package mips_pipe_pkg;
  localparam int TNEW_W = 2;
  localparam int REG_W = 5;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP = 32'h0;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rt;
    logic [REG_W-1:0] a3;
    logic link;
    logic [TNEW_W-1:0] tnew;
  } stage_t;
endpackage

// File: rtl/tnew_age.sv
// tnew_age: saturating decrement of Tnew as an instruction moves one stage down
module tnew_age #(
  parameter int W = 2
) (
  input  logic [W-1:0] tnew,
  output logic [W-1:0] aged
);
  assign aged = (tnew == '0) ? '0 : tnew - W'(1);
endmodule

// File: rtl/e_m_pipe_reg.sv
// e_m_pipe_reg: E-to-M pipeline register with Tnew aging, M-stage forward source and bubble counter
module e_m_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TNEW_W = mips_pipe_pkg::TNEW_W,
  parameter logic [WIDTH-1:0] PC_RESET = mips_pipe_pkg::PC_RESET,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [WIDTH-1:0]  E_instr,
  input  logic [WIDTH-1:0]  E_PC,
  input  logic [WIDTH-1:0]  E_ALU,
  input  logic [WIDTH-1:0]  E_RT,
  input  logic [REG_W-1:0]  E_A3,
  input  logic              E_link,
  input  logic [TNEW_W-1:0] E_Tnew,
  output logic [WIDTH-1:0]  M_instr,
  output logic [WIDTH-1:0]  M_PC,
  output logic [WIDTH-1:0]  M_ALU,
  output logic [WIDTH-1:0]  M_RT,
  output logic [REG_W-1:0]  M_A3,
  output logic [TNEW_W-1:0] M_Tnew,
  output logic              M_fwd_valid,
  output logic [REG_W-1:0]  M_fwd_A,
  output logic [WIDTH-1:0]  M_fwd_data,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic              m_link;
  logic [TNEW_W-1:0] aged_tnew;
  tnew_age #(.W(TNEW_W)) u_age (.tnew(E_Tnew), .aged(aged_tnew));
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      M_instr <= WIDTH'(NOP);
      M_PC    <= PC_RESET;
      M_ALU   <= '0;
      M_RT    <= '0;
      M_A3    <= '0;
      M_Tnew  <= '0;
      m_link  <= 1'b0;
    end else if (en) begin
      M_instr <= E_instr;
      M_PC    <= E_PC;
      M_ALU   <= E_ALU;
      M_RT    <= E_RT;
      M_A3    <= E_A3;
      M_Tnew  <= aged_tnew;
      m_link  <= E_link;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) bubble_cnt <= '0;
    else if (clr && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_W'(1);
  end
  assign M_fwd_valid = (M_Tnew == '0) && (M_A3 != '0);
  assign M_fwd_A     = M_fwd_valid ? M_A3 : '0;
  assign M_fwd_data  = !M_fwd_valid ? '0 : m_link ? M_PC + WIDTH'(8) : M_ALU;
endmodule

// File: tb/tb_e_m_pipe_reg.sv
// tb_e_m_pipe_reg: directed checks of load, aging, forwarding, stall/flush priority and counter saturation
module tb_e_m_pipe_reg;
  logic clk = 0, reset = 1, en = 0, clr = 0, E_link = 0;
  logic [31:0] E_instr = 0, E_PC = 0, E_ALU = 0, E_RT = 0;
  logic [4:0] E_A3 = 0;
  logic [1:0] E_Tnew = 0;
  logic [31:0] M_instr, M_PC, M_ALU, M_RT, M_fwd_data;
  logic [4:0] M_A3, M_fwd_A;
  logic [1:0] M_Tnew;
  logic M_fwd_valid;
  logic [3:0] bubble_cnt;
  int checks = 0, failures = 0;
  e_m_pipe_reg #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .E_instr(E_instr), .E_PC(E_PC), .E_ALU(E_ALU), .E_RT(E_RT),
    .E_A3(E_A3), .E_link(E_link), .E_Tnew(E_Tnew),
    .M_instr(M_instr), .M_PC(M_PC), .M_ALU(M_ALU), .M_RT(M_RT),
    .M_A3(M_A3), .M_Tnew(M_Tnew), .M_fwd_valid(M_fwd_valid),
    .M_fwd_A(M_fwd_A), .M_fwd_data(M_fwd_data), .bubble_cnt(bubble_cnt)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [31:0] i, pc, alu, rt, input logic [4:0] a3, input logic lk, input logic [1:0] tn);
    E_instr = i; E_PC = pc; E_ALU = alu; E_RT = rt; E_A3 = a3; E_link = lk; E_Tnew = tn;
  endtask
  task automatic chk_bubble(input string tag);
    chk({tag, "_instr"}, M_instr, 32'h0);
    chk({tag, "_pc"}, M_PC, 32'h3000);
    chk({tag, "_alu"}, M_ALU, 32'h0);
    chk({tag, "_rt"}, M_RT, 32'h0);
    chk({tag, "_a3"}, 32'(M_A3), 32'h0);
    chk({tag, "_tnew"}, 32'(M_Tnew), 32'h0);
    chk({tag, "_fv"}, 32'(M_fwd_valid), 32'h0);
    chk({tag, "_fa"}, 32'(M_fwd_A), 32'h0);
    chk({tag, "_fd"}, M_fwd_data, 32'h0);
  endtask
  initial begin
    #1;
    step(); step();
    chk_bubble("rst");
    chk("rst_cnt", 32'(bubble_cnt), 0);
    reset = 0; clr = 1;
    step();
    chk_bubble("clr1");
    chk("clr1_cnt", 32'(bubble_cnt), 1);
    clr = 0; en = 1;
    load(32'h8c08_0000, 32'h3004, 32'h1234, 32'h0, 5'd8, 0, 2'd2);
    step();
    chk("lw_tnew", 32'(M_Tnew), 1);
    chk("lw_fv", 32'(M_fwd_valid), 0);
    chk("lw_fa", 32'(M_fwd_A), 0);
    chk("lw_fd", M_fwd_data, 0);
    chk("lw_alu", M_ALU, 32'h1234);
    chk("lw_instr", M_instr, 32'h8c08_0000);
    chk("lw_a3", 32'(M_A3), 8);
    load(32'h0000_4820, 32'h3008, 32'h55, 32'h7, 5'd9, 0, 2'd1);
    step();
    chk("add_tnew", 32'(M_Tnew), 0);
    chk("add_fv", 32'(M_fwd_valid), 1);
    chk("add_fa", 32'(M_fwd_A), 9);
    chk("add_fd", M_fwd_data, 32'h55);
    chk("add_pc", M_PC, 32'h3008);
    chk("add_rt", M_RT, 32'h7);
    load(32'h0000_5020, 32'h300c, 32'h66, 32'h0, 5'd10, 0, 2'd0);
    step();
    chk("t0_tnew", 32'(M_Tnew), 0);
    chk("t0_fd", M_fwd_data, 32'h66);
    load(32'h0c00_0c00, 32'h3010, 32'hdead_beef, 32'h0, 5'd31, 1, 2'd0);
    step();
    chk("jal_fv", 32'(M_fwd_valid), 1);
    chk("jal_fa", 32'(M_fwd_A), 31);
    chk("jal_fd", M_fwd_data, 32'h3018);
    E_A3 = 0;
    step();
    chk("a30_fv", 32'(M_fwd_valid), 0);
    chk("a30_fa", 32'(M_fwd_A), 0);
    chk("a30_fd", M_fwd_data, 0);
    load(32'h0c00_0001, 32'hffff_fffc, 32'h1, 32'h0, 5'd31, 1, 2'd0);
    step();
    chk("wrap_fd", M_fwd_data, 32'h4);
    load(32'h1111_1111, 32'h3020, 32'haaaa, 32'hbbbb, 5'd5, 0, 2'd0);
    step();
    en = 0;
    for (int k = 0; k < 3; k++) begin
      load(32'h2222_0000 + k, 32'h4000 + k, 32'h77 + k, 32'h99 + k, 5'd6 + 5'(k), 1, 2'd2);
      step();
      chk("hold_instr", M_instr, 32'h1111_1111);
      chk("hold_pc", M_PC, 32'h3020);
      chk("hold_rt", M_RT, 32'hbbbb);
      chk("hold_a3", 32'(M_A3), 5);
      chk("hold_fd", M_fwd_data, 32'haaaa);
      chk("hold_cnt", 32'(bubble_cnt), 1);
    end
    clr = 1;
    step();
    chk_bubble("stallclr");
    chk("stallclr_cnt", 32'(bubble_cnt), 2);
    en = 1;
    load(32'h3333_3333, 32'h5000, 32'h1, 32'h2, 5'd7, 1, 2'd0);
    step();
    chk_bubble("enclr");
    chk("enclr_cnt", 32'(bubble_cnt), 3);
    clr = 0;
    load(32'h4444_4444, 32'h3040, 32'h88, 32'h0, 5'd12, 0, 2'd0);
    step();
    chk("pre_rst_fv", 32'(M_fwd_valid), 1);
    en = 0; reset = 1;
    step();
    chk_bubble("rststall");
    chk("rststall_cnt", 32'(bubble_cnt), 0);
    reset = 0;
    step();
    chk_bubble("rststall2");
    clr = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("sat_cnt", 32'(bubble_cnt), (k + 1 > 15) ? 15 : k + 1);
    end
    reset = 1;
    step();
    chk("sat_rst_cnt", 32'(bubble_cnt), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
